// File: rtl/rv_issue_stage.sv
// ----------------------------------------------------------------------------
// rv_issue_stage
//
// Decode/issue stage that sits directly in front of the ALU stage. It takes
// one RV32I instruction per valid/ready handshake and decodes ADDI only. A
// legal ADDI is issued to the ALU for exactly one cycle. The stage then waits
// for the ALU's result_ready, captures the result and emits a one-cycle
// writeback strobe. If the result does not arrive within TIMEOUT_CYCLES, the
// instruction is abandoned and timeout_err pulses instead.
//
// Ports
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   instr_valid/instr     upstream instruction word
//   instr_ready           high while idle (combinational from state)
//   regfile_rd0_addr      tied to x0 (reserved for R-type)
//   regfile_rd1_addr      rs1 of the instruction being issued
//   immediate             instr[31:20] of the instruction being issued
//   input_a_is_immediate  high during the issue cycle
//   alu_op                ALU_ADD during the issue cycle, otherwise ALU_NONE
//   result_ready          ALU result valid
//   alu_result            ALU result
//   wb_en/wb_rd_addr/wb_data  one-cycle writeback strobe, destination, data
//   illegal_instr         one-cycle pulse for an undecodable instruction
//   timeout_err           one-cycle pulse when the wait for a result expires
//   retired_count         completed instructions, including rd==x0, wrapping
// ----------------------------------------------------------------------------
package rv_issue_pkg;
   typedef enum logic [1:0] {
      ALU_NONE = 2'd0,
      ALU_ADD  = 2'd1
   } alu_command_t;
endpackage

module rv_issue_stage
   import rv_issue_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8   // legal range 1..255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         instr_valid,
   input  logic [31:0]  instr,
   output logic         instr_ready,
   output logic [4:0]   regfile_rd1_addr,
   output logic [4:0]   regfile_rd0_addr,
   output logic [11:0]  immediate,
   output logic         input_a_is_immediate,
   output alu_command_t alu_op,
   input  logic         result_ready,
   input  logic [31:0]  alu_result,
   output logic         wb_en,
   output logic [4:0]   wb_rd_addr,
   output logic [31:0]  wb_data,
   output logic         illegal_instr,
   output logic         timeout_err,
   output logic [31:0]  retired_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [2:0] F3_ADDI      = 3'b000;
   // Last counter value before the wait is abandoned.
   localparam logic [7:0] WAIT_LAST    = 8'(TIMEOUT_CYCLES - 1);

   state_t       state_q, state_d;
   logic [4:0]   rd_q, rd_d;
   logic [4:0]   rs1_q, rs1_d;
   logic [11:0]  imm_q, imm_d;
   logic [7:0]   wait_cnt_q, wait_cnt_d;
   alu_command_t alu_op_q, alu_op_d;
   logic         a_is_imm_q, a_is_imm_d;
   logic         wb_en_q, wb_en_d;
   logic [4:0]   wb_rd_q, wb_rd_d;
   logic [31:0]  wb_data_q, wb_data_d;
   logic         illegal_q, illegal_d;
   logic         timeout_q, timeout_d;
   logic [31:0]  retired_q, retired_d;

   logic         instr_legal;

   assign instr_legal = (instr[6:0] == OPC_OP_IMM) && (instr[14:12] == F3_ADDI);

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      imm_d      = imm_q;
      wait_cnt_d = wait_cnt_q;
      alu_op_d   = ALU_NONE;
      a_is_imm_d = 1'b0;
      wb_en_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      timeout_d  = 1'b0;
      retired_d  = retired_q;

      case (state_q)
         ST_IDLE: begin
            // instr_ready is implied by being in IDLE.
            if (instr_valid) begin
               if (instr_legal) begin
                  rd_d       = instr[11:7];
                  rs1_d      = instr[19:15];
                  imm_d      = instr[31:20];
                  // Issue outputs are registered, so they are set up here
                  // to be visible during the ISSUE cycle.
                  alu_op_d   = ALU_ADD;
                  a_is_imm_d = 1'b1;
                  state_d    = ST_ISSUE;
               end else begin
                  illegal_d  = 1'b1;
               end
            end
         end

         ST_ISSUE: begin
            wait_cnt_d = 8'd0;
            state_d    = ST_WAIT;
         end

         ST_WAIT: begin
            // A result arriving on the final counter value still wins.
            if (result_ready) begin
               wb_data_d = alu_result;
               wb_rd_d   = rd_q;
               wb_en_d   = (rd_q != 5'd0);
               retired_d = retired_q + 32'd1;
               state_d   = ST_IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rd_q       <= 5'd0;
         rs1_q      <= 5'd0;
         imm_q      <= 12'd0;
         wait_cnt_q <= 8'd0;
         alu_op_q   <= ALU_NONE;
         a_is_imm_q <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         retired_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         imm_q      <= imm_d;
         wait_cnt_q <= wait_cnt_d;
         alu_op_q   <= alu_op_d;
         a_is_imm_q <= a_is_imm_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
         retired_q  <= retired_d;
      end
   end

   assign instr_ready          = (state_q == ST_IDLE);
   assign regfile_rd0_addr     = 5'd0;
   assign regfile_rd1_addr     = rs1_q;
   assign immediate            = imm_q;
   assign input_a_is_immediate = a_is_imm_q;
   assign alu_op               = alu_op_q;
   assign wb_en                = wb_en_q;
   assign wb_rd_addr           = wb_rd_q;
   assign wb_data              = wb_data_q;
   assign illegal_instr        = illegal_q;
   assign timeout_err          = timeout_q;
   assign retired_count        = retired_q;

endmodule
